// File: rtl/dbgapb_arb.sv
// Two-requester arbiter onto the single debug APB slave port: grants one requester,
// replays its transfer downstream as SETUP/ACCESS and routes the response back to it.
module dbgapb_arb #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_psel,
  input  logic                m0_penable,
  input  logic [ADDR_W-1:0]   m0_paddr,
  input  logic                m0_pwrite,
  input  logic [DATA_W/8-1:0] m0_pstrb,
  input  logic [2:0]          m0_pprot,
  input  logic [DATA_W-1:0]   m0_pwdata,
  output logic [DATA_W-1:0]   m0_prdata,
  output logic                m0_pslverr,
  output logic                m0_pready,
  input  logic                m1_psel,
  input  logic                m1_penable,
  input  logic [ADDR_W-1:0]   m1_paddr,
  input  logic                m1_pwrite,
  input  logic [DATA_W/8-1:0] m1_pstrb,
  input  logic [2:0]          m1_pprot,
  input  logic [DATA_W-1:0]   m1_pwdata,
  output logic [DATA_W-1:0]   m1_prdata,
  output logic                m1_pslverr,
  output logic                m1_pready,
  output logic                dbg_psel,
  output logic                dbg_penable,
  output logic                dbg_pwrite,
  output logic [ADDR_W-1:0]   dbg_paddr,
  output logic [DATA_W/8-1:0] dbg_pstrb,
  output logic [2:0]          dbg_pprot,
  output logic [DATA_W-1:0]   dbg_pwdata,
  input  logic [DATA_W-1:0]   dbg_prdata,
  input  logic                dbg_pslverr,
  input  logic                dbg_pready,
  output logic                grant_id
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int CNT_W   = $clog2(TIMEOUT) + 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [2:0]          prot_q, prot_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic win, done, abort, resp, own0, own1, err_out;
  logic [DATA_W-1:0] rdata_out;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    write_d = write_q;
    strb_d  = strb_q;
    prot_d  = prot_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;

    // A lone requester wins; a tie goes to requester 0 or alternates.
    win   = (m0_psel && m1_psel) ? ((PRIO_MODE != 0) ? 1'b0 : ~last_q) : m1_psel;
    done  = (state_q == ACCESS) && dbg_pready;
    abort = (state_q == ACCESS) && !dbg_pready && (TIMEOUT != 0) &&
            (cnt_q == CNT_W'(TO_LAST));

    case (state_q)
      IDLE: begin
        if (m0_psel || m1_psel) begin
          grant_d = win;
          last_d  = win;
          addr_d  = win ? m1_paddr  : m0_paddr;
          write_d = win ? m1_pwrite : m0_pwrite;
          strb_d  = win ? m1_pstrb  : m0_pstrb;
          prot_d  = win ? m1_pprot  : m0_pprot;
          wdata_d = win ? m1_pwdata : m0_pwdata;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (done || abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      write_q <= 1'b0;
      strb_q  <= '0;
      prot_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      strb_q  <= strb_d;
      prot_q  <= prot_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // A response is dropped if the owner abandoned its transfer.
  assign resp      = done || abort;
  assign own0      = !grant_q && m0_psel;
  assign own1      = grant_q && m1_psel;
  assign err_out   = abort || (done && dbg_pslverr);
  assign rdata_out = (done && !write_q) ? dbg_prdata : '0;

  assign m0_pready  = resp && own0;
  assign m0_pslverr = resp && own0 && err_out;
  assign m0_prdata  = (resp && own0) ? rdata_out : '0;
  assign m1_pready  = resp && own1;
  assign m1_pslverr = resp && own1 && err_out;
  assign m1_prdata  = (resp && own1) ? rdata_out : '0;

  assign dbg_psel    = (state_q != IDLE);
  assign dbg_penable = (state_q == ACCESS);
  assign dbg_paddr   = addr_q;
  assign dbg_pwrite  = write_q;
  assign dbg_pstrb   = strb_q;
  assign dbg_pprot   = prot_q;
  assign dbg_pwdata  = wdata_q;
  assign grant_id    = grant_q;

endmodule

// File: tb/tb_dbgapb_arb.sv
// Directed bench: instance 0 round-robin, instance 1 fixed priority, both TIMEOUT=8,
// each with a behavioural downstream slave whose wait states are set per test.
module tb_dbgapb_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  m_psel [2], m_penable [2], m_pwrite [2], m_pslverr [2], m_pready [2];
  logic [31:0] m_paddr [2][2], m_pwdata [2][2], m_prdata [2][2];
  logic [3:0]  m_pstrb [2][2];
  logic [2:0]  m_pprot [2][2];
  logic [1:0]  dbg_psel, dbg_penable, dbg_pwrite, dbg_pslverr, dbg_pready, grant_id;
  logic [31:0] dbg_paddr [2], dbg_pwdata [2], dbg_prdata [2];
  logic [3:0]  dbg_pstrb [2];
  logic [2:0]  dbg_pprot [2];

  int          wait_cfg [2];
  logic [31:0] rdata_cfg [2];
  logic [1:0]  serr_cfg;
  int          acc_cnt [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      dbgapb_arb #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(gi), .TIMEOUT(8)) u_dut (
        .clk(clk), .rst(rst),
        .m0_psel(m_psel[gi][0]), .m0_penable(m_penable[gi][0]), .m0_paddr(m_paddr[gi][0]),
        .m0_pwrite(m_pwrite[gi][0]), .m0_pstrb(m_pstrb[gi][0]), .m0_pprot(m_pprot[gi][0]),
        .m0_pwdata(m_pwdata[gi][0]), .m0_prdata(m_prdata[gi][0]),
        .m0_pslverr(m_pslverr[gi][0]), .m0_pready(m_pready[gi][0]),
        .m1_psel(m_psel[gi][1]), .m1_penable(m_penable[gi][1]), .m1_paddr(m_paddr[gi][1]),
        .m1_pwrite(m_pwrite[gi][1]), .m1_pstrb(m_pstrb[gi][1]), .m1_pprot(m_pprot[gi][1]),
        .m1_pwdata(m_pwdata[gi][1]), .m1_prdata(m_prdata[gi][1]),
        .m1_pslverr(m_pslverr[gi][1]), .m1_pready(m_pready[gi][1]),
        .dbg_psel(dbg_psel[gi]), .dbg_penable(dbg_penable[gi]), .dbg_pwrite(dbg_pwrite[gi]),
        .dbg_paddr(dbg_paddr[gi]), .dbg_pstrb(dbg_pstrb[gi]), .dbg_pprot(dbg_pprot[gi]),
        .dbg_pwdata(dbg_pwdata[gi]), .dbg_prdata(dbg_prdata[gi]),
        .dbg_pslverr(dbg_pslverr[gi]), .dbg_pready(dbg_pready[gi]), .grant_id(grant_id[gi])
      );
      // Slave answers on the (wait_cfg+1)-th ACCESS cycle; a negative wait never answers.
      assign dbg_pready[gi]  = dbg_psel[gi] && dbg_penable[gi] && (wait_cfg[gi] >= 0) &&
                               (acc_cnt[gi] == wait_cfg[gi]);
      assign dbg_prdata[gi]  = rdata_cfg[gi];
      assign dbg_pslverr[gi] = serr_cfg[gi] & dbg_pready[gi];
    end
  endgenerate

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      acc_cnt[k] <= (dbg_psel[k] && dbg_penable[k] && !dbg_pready[k]) ? acc_cnt[k] + 1 : 0;
  end

  int   rdy_cnt [2][2];
  int   issued [2][2];
  int   hold_err [2];
  logic prev_acc [2], prev_done [2];
  logic [31:0] prev_addr [2];

  // Downstream must hold psel/penable and address until the transfer ends.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (prev_acc[k] && !prev_done[k] && !rst && !(dbg_psel[k] && dbg_penable[k]))
        hold_err[k] <= hold_err[k] + 1;
      else if (prev_acc[k] && !rst && dbg_psel[k] && dbg_penable[k] && dbg_paddr[k] != prev_addr[k])
        hold_err[k] <= hold_err[k] + 1;
      prev_acc[k]  <= dbg_psel[k] && dbg_penable[k];
      prev_done[k] <= dbg_pready[k] || m_pready[k][0] || m_pready[k][1];
      prev_addr[k] <= dbg_paddr[k];
      for (int m = 0; m < 2; m++)
        if (m_pready[k][m]) rdy_cnt[k][m] <= rdy_cnt[k][m] + 1;
    end
  end

  typedef struct {
    logic [31:0] rd; logic err; int lat; logic [31:0] addr; logic wr;
    logic [31:0] wd; logic [3:0] strb; logic [2:0] prot; logic gid;
  } cap_t;

  typedef struct {
    int m; logic [31:0] addr; logic wr; logic [31:0] wdata; int wt;
    logic [31:0] srd; logic serr; logic [31:0] exp_rd; logic exp_err; int exp_lat;
  } vec_t;

  int   nvec = 0;
  int   nfail = 0;
  int   comp_log [$];
  cap_t res [2];
  cap_t pc [3];
  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Caller must be at posedge+1; the task returns at posedge+1 with psel low,
  // so calling it again immediately gives a back-to-back transfer.
  task automatic xfer(input int k, input int m, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wd, output cap_t c);
    bit done = 1'b0;
    issued[k][m]++;
    c = '{default: '0};
    m_paddr[k][m]  = addr;
    m_pwrite[k][m] = wr;
    m_pwdata[k][m] = wd;
    m_pstrb[k][m]  = (m == 0) ? 4'h3 : 4'hC;
    m_pprot[k][m]  = (m == 0) ? 3'b010 : 3'b101;
    m_psel[k][m]   = 1'b1;
    m_penable[k][m] = 1'b0;
    @(posedge clk); #1;
    m_penable[k][m] = 1'b1;
    c.lat = 1;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (m_pready[k][m]) begin
        done   = 1'b1;
        c.rd   = m_prdata[k][m];
        c.err  = m_pslverr[k][m];
        c.addr = dbg_paddr[k];
        c.wr   = dbg_pwrite[k];
        c.wd   = dbg_pwdata[k];
        c.strb = dbg_pstrb[k];
        c.prot = dbg_pprot[k];
        c.gid  = grant_id[k];
        comp_log.push_back(m);
      end else begin
        @(posedge clk); #1;
        c.lat++;
      end
    end
    chk($sformatf("ready_seen_k%0d_m%0d", k, m), 32'(done), 32'd1);
    $display("xfer k%0d m%0d %s addr=%h lat=%0d rd=%h err=%0d gid=%0d",
             k, m, wr ? "WR" : "RD", addr, c.lat, c.rd, c.err, c.gid);
    @(posedge clk); #1;
    m_psel[k][m]    = 1'b0;
    m_penable[k][m] = 1'b0;
  endtask

  // Both requesters issue a write in the same cycle; requester 0 is expected to win.
  task automatic pair(input int k, input string tag);
    comp_log.delete();
    fork
      xfer(k, 0, 32'h10, 1'b1, 32'hA5A5_0001, res[0]);
      xfer(k, 1, 32'h14, 1'b1, 32'h0000_00FF, res[1]);
    join
    chk({tag, "_ncomp"}, 32'(comp_log.size()), 32'd2);
    chk({tag, "_first"}, 32'(comp_log[0]), 32'd0);
    chk({tag, "_gid0"}, 32'(res[0].gid), 32'd0);
    chk({tag, "_gid1"}, 32'(res[1].gid), 32'd1);
    chk({tag, "_lat0"}, 32'(res[0].lat), 32'd2);
    chk({tag, "_lat1"}, 32'(res[1].lat), 32'd5);
    chk({tag, "_wd0"}, res[0].wd, 32'hA5A5_0001);
    chk({tag, "_addr1"}, res[1].addr, 32'h14);
    chk({tag, "_rd1"}, res[1].rd, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cap_t c;
    bit seen;
    vt[0] = '{0, 32'h04, 1'b0, 32'h0,         0, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 2};
    vt[1] = '{1, 32'h08, 1'b0, 32'h0,         1, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 3};
    vt[2] = '{0, 32'h10, 1'b1, 32'hA5A5_0001, 0, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0, 2};
    vt[3] = '{1, 32'h14, 1'b1, 32'h0000_00FF, 5, 32'h1111_1111, 1'b0, 32'h0,         1'b0, 7};
    vt[4] = '{0, 32'h20, 1'b0, 32'h0,         2, 32'h0000_0055, 1'b1, 32'h0000_0055, 1'b1, 4};
    vt[5] = '{1, 32'h24, 1'b0, 32'h0,        -1, 32'h0000_0077, 1'b0, 32'h0,         1'b1, 9};
    vt[6] = '{0, 32'h28, 1'b0, 32'h0,         0, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 2};
    vt[7] = '{0, 32'h2C, 1'b0, 32'h0,         7, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0, 9};

    for (int k = 0; k < 2; k++) begin
      m_psel[k] = 2'b00; m_penable[k] = 2'b00; m_pwrite[k] = 2'b00;
      for (int m = 0; m < 2; m++) begin
        m_paddr[k][m] = '0; m_pwdata[k][m] = '0; m_pstrb[k][m] = '0; m_pprot[k][m] = '0;
      end
      wait_cfg[k] = 0; rdata_cfg[k] = '0;
    end
    serr_cfg = 2'b00;

    rst = 1'b1;
    #12;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_psel_k%0d", k), 32'(dbg_psel[k]), 32'd0);
      chk($sformatf("rst_penable_k%0d", k), 32'(dbg_penable[k]), 32'd0);
      chk($sformatf("rst_paddr_k%0d", k), dbg_paddr[k], 32'd0);
      chk($sformatf("rst_gid_k%0d", k), 32'(grant_id[k]), 32'd0);
      chk($sformatf("rst_pready_k%0d", k), 32'(m_pready[k]), 32'd0);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    pair(0, "rr_round1");
    pair(0, "rr_round2");

    for (int i = 0; i < 8; i++) begin
      wait_cfg[0]  = vt[i].wt;
      rdata_cfg[0] = vt[i].srd;
      serr_cfg[0]  = vt[i].serr;
      xfer(0, vt[i].m, vt[i].addr, vt[i].wr, vt[i].wdata, c);
      chk($sformatf("v%0d_rd", i), c.rd, vt[i].exp_rd);
      chk($sformatf("v%0d_err", i), 32'(c.err), 32'(vt[i].exp_err));
      chk($sformatf("v%0d_lat", i), 32'(c.lat), 32'(vt[i].exp_lat));
      chk($sformatf("v%0d_addr", i), c.addr, vt[i].addr);
      chk($sformatf("v%0d_wr", i), 32'(c.wr), 32'(vt[i].wr));
      chk($sformatf("v%0d_wd", i), c.wd, vt[i].wdata);
      chk($sformatf("v%0d_gid", i), 32'(c.gid), 32'(vt[i].m));
      chk($sformatf("v%0d_strb", i), 32'(c.strb), (vt[i].m == 0) ? 32'h3 : 32'hC);
      chk($sformatf("v%0d_prot", i), 32'(c.prot), (vt[i].m == 0) ? 32'h2 : 32'h5);
    end

    // Fixed priority: requester 0 keeps re-requesting back-to-back and starves requester 1.
    comp_log.delete();
    wait_cfg[1]  = 0;
    rdata_cfg[1] = 32'h600D_0000;
    fork
      begin
        for (int j = 0; j < 3; j++) xfer(1, 0, 32'(32'h40 + 4 * j), 1'b0, 32'h0, pc[j]);
      end
      xfer(1, 1, 32'h50, 1'b0, 32'h0, res[1]);
    join
    chk("prio_ncomp", 32'(comp_log.size()), 32'd4);
    chk("prio_last", 32'(comp_log[3]), 32'd1);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("prio_m0_lat%0d", j), 32'(pc[j].lat), 32'd2);
      chk($sformatf("prio_m0_addr%0d", j), pc[j].addr, 32'(32'h40 + 4 * j));
    end
    chk("prio_m1_lat", 32'(res[1].lat), 32'd11);
    chk("prio_m1_rd", res[1].rd, 32'h600D_0000);
    chk("prio_m1_gid", 32'(res[1].gid), 32'd1);

    // Reset during ACCESS of a requester-1 transfer on the round-robin instance.
    wait_cfg[0] = -1;
    m_paddr[0][1] = 32'h30; m_pwrite[0][1] = 1'b0; m_pstrb[0][1] = 4'hC; m_pprot[0][1] = 3'b101;
    m_psel[0][1] = 1'b1; m_penable[0][1] = 1'b0;
    @(posedge clk); #1;
    m_penable[0][1] = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = dbg_penable[0];
    end
    chk("rst_mid_access_seen", 32'(seen), 32'd1);
    chk("rst_mid_gid_before", 32'(grant_id[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_psel", 32'(dbg_psel[0]), 32'd0);
    chk("rst_mid_penable", 32'(dbg_penable[0]), 32'd0);
    chk("rst_mid_paddr", dbg_paddr[0], 32'd0);
    chk("rst_mid_prot", 32'(dbg_pprot[0]), 32'd0);
    chk("rst_mid_gid", 32'(grant_id[0]), 32'd0);
    chk("rst_mid_m1_pready", 32'(m_pready[0][1]), 32'd0);
    m_psel[0][1] = 1'b0; m_penable[0][1] = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cfg[0] = 0;
    pair(0, "post_rst");

    for (int k = 0; k < 2; k++) begin
      chk($sformatf("hold_k%0d", k), 32'(hold_err[k]), 32'd0);
      for (int m = 0; m < 2; m++)
        chk($sformatf("pready_count_k%0d_m%0d", k, m), 32'(rdy_cnt[k][m]), 32'(issued[k][m]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
